// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run/step/halt sequencer for a 5-stage pipeline
// Owns stage enables, hazard bubbles and the cycle/stall performance counters.
module pipeline_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic             i_halt_wb,
  input  logic             i_load_use,
  output logic             o_cmd_ready,
  output logic             o_cmd_err,
  output logic             o_stage_en,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_bubble,
  output logic             o_id_ex_bubble,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_HALT  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               cmd_acc;

  always_comb begin
    o_cmd_ready    = (state == S_IDLE) || (state == S_RUN) || (state == S_HALTED);
    o_stage_en     = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
    // During drain the front end is frozen while bubbles flush the back end.
    o_pc_write     = o_stage_en & ~i_load_use & (state != S_DRAIN);
    o_if_id_write  = o_pc_write;
    o_if_id_bubble = (state == S_DRAIN);
    o_id_ex_bubble = o_stage_en & i_load_use;
    o_state        = state;
    cmd_acc        = i_cmd_valid & o_cmd_ready;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      o_cycle_cnt <= '0;
      o_stall_cnt <= '0;
      o_cmd_err   <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_cmd_err <= 1'b0;
      o_done    <= 1'b0;
      if (o_stage_en && (o_cycle_cnt != '1))
        o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
      if (o_id_ex_bubble && (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (cmd_acc) begin
            case (i_cmd)
              CMD_RUN:  state <= S_RUN;
              CMD_STEP: state <= S_STEP;
              default:  o_cmd_err <= 1'b1;
            endcase
          end
        end
        S_RUN: begin
          // A retiring HALT instruction beats any host command.
          if (i_halt_wb) begin
            state  <= S_HALTED;
            o_done <= 1'b1;
          end else if (cmd_acc) begin
            if (i_cmd == CMD_HALT) begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end else begin
              o_cmd_err <= 1'b1;
            end
          end
        end
        S_STEP: begin
          state  <= i_halt_wb ? S_HALTED : S_IDLE;
          o_done <= 1'b1;
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - DRAIN_W'(1);
          if (i_halt_wb || (drain_cnt == DRAIN_W'(1))) begin
            state  <= S_HALTED;
            o_done <= 1'b1;
          end
        end
        S_HALTED: begin
          if (cmd_acc) begin
            if (i_cmd == CMD_CLEAR) begin
              state       <= S_IDLE;
              o_cycle_cnt <= '0;
              o_stall_cnt <= '0;
            end else begin
              o_cmd_err <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb/tb_pipeline_run_ctrl.sv - vector table, directed sequences and random model check
module tb_pipeline_run_ctrl;

  localparam int DRAIN = 4;
  localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, HALT = 2'b10, CLEAR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, halt_wb, load_use;
  logic [1:0] cmd;

  logic        a_rdy, a_err, a_en, a_pcw, a_ifw, a_ifb, a_idb, a_done;
  logic [2:0]  a_state;
  logic [31:0] a_cyc, a_stall;
  logic        b_rdy, b_err, b_en, b_pcw, b_ifw, b_ifb, b_idb, b_done;
  logic [2:0]  b_state;
  logic [3:0]  b_cyc, b_stall;

  pipeline_run_ctrl #(.CNT_W(32), .DRAIN_CYCLES(DRAIN)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_halt_wb(halt_wb), .i_load_use(load_use),
    .o_cmd_ready(a_rdy), .o_cmd_err(a_err), .o_stage_en(a_en), .o_pc_write(a_pcw),
    .o_if_id_write(a_ifw), .o_if_id_bubble(a_ifb), .o_id_ex_bubble(a_idb),
    .o_state(a_state), .o_done(a_done), .o_cycle_cnt(a_cyc), .o_stall_cnt(a_stall)
  );

  pipeline_run_ctrl #(.CNT_W(4), .DRAIN_CYCLES(DRAIN)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_halt_wb(halt_wb), .i_load_use(load_use),
    .o_cmd_ready(b_rdy), .o_cmd_err(b_err), .o_stage_en(b_en), .o_pc_write(b_pcw),
    .o_if_id_write(b_ifw), .o_if_id_bubble(b_ifb), .o_id_ex_bubble(b_idb),
    .o_state(b_state), .o_done(b_done), .o_cycle_cnt(b_cyc), .o_stall_cnt(b_stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers for mode, drain cycles remaining and unbounded counts.
  bit     m_valid = 1'b0;
  int     m_state, m_remain;
  longint m_cyc, m_stall;
  bit     m_done, m_err;

  function automatic bit m_ready();
    return (m_state == 0) || (m_state == 1) || (m_state == 4);
  endfunction

  function automatic bit m_en();
    return (m_state == 1) || (m_state == 2) || (m_state == 3);
  endfunction

  function automatic longint sat15(input longint x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic model_check();
    bit en, pcw;
    en  = m_en();
    pcw = en && !load_use && (m_state != 3);
    chk("m.state", a_state, m_state);
    chk("m.ready", a_rdy, m_ready());
    chk("m.stage_en", a_en, en);
    chk("m.pc_write", a_pcw, pcw);
    chk("m.if_id_write", a_ifw, pcw);
    chk("m.if_id_bubble", a_ifb, m_state == 3);
    chk("m.id_ex_bubble", a_idb, en && load_use);
    chk("m.done", a_done, m_done);
    chk("m.err", a_err, m_err);
    chk("m.cycle_cnt", a_cyc, m_cyc);
    chk("m.stall_cnt", a_stall, m_stall);
    chk("m.b_state", b_state, m_state);
    chk("m.b_cycle_cnt", b_cyc, sat15(m_cyc));
    chk("m.b_stall_cnt", b_stall, sat15(m_stall));
  endtask

  task automatic model_step(input logic r, input logic v, input logic [1:0] c,
                            input logic hw, input logic lu);
    bit en, acc;
    en  = m_en();
    acc = v && m_ready();
    if (!r) begin
      m_state = 0; m_remain = 0; m_cyc = 0; m_stall = 0;
      m_done = 0; m_err = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    m_done = 0;
    m_err  = 0;
    if (en) m_cyc++;
    if (en && lu) m_stall++;
    case (m_state)
      0: if (acc) begin
           if (c == RUN) m_state = 1;
           else if (c == STEP) m_state = 2;
           else m_err = 1;
         end
      1: if (hw) begin
           m_state = 4; m_done = 1;
         end else if (acc) begin
           if (c == HALT) begin m_state = 3; m_remain = DRAIN; end
           else m_err = 1;
         end
      2: begin m_state = hw ? 4 : 0; m_done = 1; end
      3: begin
           m_remain--;
           if (hw || m_remain == 0) begin m_state = 4; m_done = 1; end
         end
      4: if (acc) begin
           if (c == CLEAR) begin m_state = 0; m_cyc = 0; m_stall = 0; end
           else m_err = 1;
         end
      default: m_state = 0;
    endcase
  endtask

  logic        s_en, s_pcw, s_ifw, s_ifb, s_idb, s_done, s_err, s_rdy;
  logic [2:0]  s_state;
  logic [31:0] s_cyc, s_stall;
  logic [3:0]  s_bcyc;

  task automatic cycle(input logic r, input logic v, input logic [1:0] c,
                       input logic hw, input logic lu);
    rst_n = r; cmd_valid = v; cmd = c; halt_wb = hw; load_use = lu;
    @(negedge clk);
    s_en = a_en; s_pcw = a_pcw; s_ifw = a_ifw; s_ifb = a_ifb; s_idb = a_idb;
    s_done = a_done; s_err = a_err; s_rdy = a_rdy; s_state = a_state;
    s_cyc = a_cyc; s_stall = a_stall; s_bcyc = b_cyc;
    if (m_valid) model_check();
    @(posedge clk);
    model_step(r, v, c, hw, lu);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, RUN, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       hw, lu;
    int         st;
    logic       en, pcw, ifb, idb, done, err, rdy;
    int         cyc, stall;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, dn_cnt;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = RUN; halt_wb = 1'b0; load_use = 1'b0;

    // Reset state
    do_reset();
    do_reset();
    cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    chk("rst.ready", s_rdy, 1);
    chk("rst.stage_en", s_en, 0);
    chk("rst.pc_write", s_pcw, 0);
    chk("rst.if_id_write", s_ifw, 0);
    chk("rst.if_id_bubble", s_ifb, 0);
    chk("rst.id_ex_bubble", s_idb, 0);
    chk("rst.state", s_state, 0);
    chk("rst.cnt", s_cyc, 0);

    //             v  c      hw lu  st en pcw ifb idb dn er rdy cyc stl
    tbl.push_back('{1, RUN,   0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, RUN,   0, 0,  1, 1, 1, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, RUN,   0, 1,  1, 1, 0, 0, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{1, HALT,  0, 0,  1, 1, 1, 0, 0, 0, 0, 1, 2, 1});
    tbl.push_back('{0, RUN,   0, 0,  3, 1, 0, 1, 0, 0, 0, 0, 3, 1});
    tbl.push_back('{1, RUN,   0, 0,  3, 1, 0, 1, 0, 0, 0, 0, 4, 1});
    tbl.push_back('{0, RUN,   0, 0,  3, 1, 0, 1, 0, 0, 0, 0, 5, 1});
    tbl.push_back('{0, RUN,   0, 1,  3, 1, 0, 1, 1, 0, 0, 0, 6, 1});
    tbl.push_back('{1, RUN,   0, 0,  4, 0, 0, 0, 0, 1, 0, 1, 7, 2});
    tbl.push_back('{1, CLEAR, 0, 0,  4, 0, 0, 0, 0, 0, 1, 1, 7, 2});
    tbl.push_back('{1, CLEAR, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, STEP,  0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, HALT,  0, 1,  2, 1, 0, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, RUN,   0, 0,  0, 0, 0, 0, 0, 1, 0, 1, 1, 1});
    tbl.push_back('{1, RUN,   0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{1, HALT,  1, 0,  1, 1, 1, 0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{0, RUN,   0, 0,  4, 0, 0, 0, 0, 1, 0, 1, 2, 1});
    for (int k = 0; k < tbl.size(); k++) begin
      cycle(1'b1, tbl[k].v, tbl[k].c, tbl[k].hw, tbl[k].lu);
      chk($sformatf("tbl%0d.state", k), s_state, tbl[k].st);
      chk($sformatf("tbl%0d.stage_en", k), s_en, tbl[k].en);
      chk($sformatf("tbl%0d.pc_write", k), s_pcw, tbl[k].pcw);
      chk($sformatf("tbl%0d.if_id_bubble", k), s_ifb, tbl[k].ifb);
      chk($sformatf("tbl%0d.id_ex_bubble", k), s_idb, tbl[k].idb);
      chk($sformatf("tbl%0d.done", k), s_done, tbl[k].done);
      chk($sformatf("tbl%0d.err", k), s_err, tbl[k].err);
      chk($sformatf("tbl%0d.ready", k), s_rdy, tbl[k].rdy);
      chk($sformatf("tbl%0d.cycle_cnt", k), s_cyc, tbl[k].cyc);
      chk($sformatf("tbl%0d.stall_cnt", k), s_stall, tbl[k].stall);
    end

    // RUN for 10 cycles, halt retires in WB on the 10th
    do_reset();
    cycle(1'b1, 1'b1, RUN, 1'b0, 1'b0);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, RUN, (i == 9), 1'b0);
      en_cnt += int'(s_en);
    end
    cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    chk("run10.en_cycles", en_cnt, 10);
    chk("run10.state", s_state, 4);
    chk("run10.done", s_done, 1);
    chk("run10.stage_en", s_en, 0);
    chk("run10.cycle_cnt", s_cyc, 10);
    cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    chk("run10.done_pulse", s_done, 0);

    // Three single steps
    do_reset();
    en_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, STEP, 1'b0, 1'b0);
      en_cnt += int'(s_en); dn_cnt += int'(s_done);
      cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
      en_cnt += int'(s_en); dn_cnt += int'(s_done);
      cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
      en_cnt += int'(s_en); dn_cnt += int'(s_done);
    end
    chk("step3.en_cycles", en_cnt, 3);
    chk("step3.done_cnt", dn_cnt, 3);
    chk("step3.cycle_cnt", s_cyc, 3);
    chk("step3.state", s_state, 0);

    // Load-use stalls while running
    do_reset();
    cycle(1'b1, 1'b1, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, RUN, 1'b0, 1'b1);
      chk("lu.pc_write", s_pcw, 0);
      chk("lu.id_ex_bubble", s_idb, 1);
    end
    cycle(1'b1, 1'b0, RUN, 1'b1, 1'b0);
    chk("lu.stall_cnt", s_stall, 2);
    chk("lu.pc_write_after", s_pcw, 1);

    // Illegal HALT in IDLE
    do_reset();
    cycle(1'b1, 1'b1, HALT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    chk("idle_halt.err", s_err, 1);
    chk("idle_halt.state", s_state, 0);
    cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    chk("idle_halt.err_pulse", s_err, 0);

    // Reset in the middle of DRAIN
    cycle(1'b1, 1'b1, RUN, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, HALT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    chk("middrain.state", s_state, 3);
    cycle(1'b0, 1'b0, RUN, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    chk("middrain.rst_state", s_state, 0);
    chk("middrain.cycle_cnt", s_cyc, 0);
    chk("middrain.stall_cnt", s_stall, 0);

    // Narrow counter saturates
    cycle(1'b1, 1'b1, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, RUN, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, RUN, 1'b1, 1'b0);
    chk("sat.b_cycle_cnt", s_bcyc, 15);
    chk("sat.a_cycle_cnt", s_cyc, 20);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 63) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
